// File: rtl/rstseq_pkg.sv
// ---------------------------------------------------------------------------
// rstseq_pkg
//
// Purpose : Shared types and helpers for the reset release sequencer.
//           Holds the sequencer state encoding, which is also exported on
//           the STATE debug port, and a constant function used at
//           elaboration time to confirm the stage delay fits its counter.
//
// Contents:
//   STATE_W          width of the exported state encoding
//   rstseq_state_e   SYNC / RELEASE / RUN / SW_HOLD
//   delayFits()      true when delay is in 1 .. 2^width-1
// ---------------------------------------------------------------------------
package rstseq_pkg;

   localparam int STATE_W = 2;

   // The encoding is visible to software through the STATE debug port,
   // so the values are pinned explicitly.
   typedef enum logic [STATE_W-1:0] {
      SYNC    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      SW_HOLD = 2'd3
   } rstseq_state_e;

   // The delay counter is compared against delay-1 and never wraps, so the
   // delay has to be at least one cycle and strictly below 2^width.
   function automatic bit delayFits(input int delay, input int width);
      return (delay >= 1) && (width >= 1) && (width < 31) && (delay < (1 << width));
   endfunction

endpackage

// File: rtl/rstn_sync_chain.sv
// ---------------------------------------------------------------------------
// rstn_sync_chain
//
// Purpose : Reset deassertion synchronizer. A constant 1 is shifted through
//           DEPTH flops that are all cleared asynchronously while rst_ni is
//           low, so assertion is immediate and deassertion is seen by the
//           clock domain only after DEPTH rising edges.
//
// Parameters:
//   DEPTH   number of flops in the chain (>= 1)
//
// Ports:
//   clk_i   input  1  rising-edge clock
//   rst_ni  input  1  asynchronous active-low clear
//   sync_o  output 1  synchronized "out of reset" level (last flop)
// ---------------------------------------------------------------------------
module rstn_sync_chain #(
   parameter int DEPTH = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic sync_o
);

   logic [DEPTH-1:0] stage_q;

   // Shift a 1 in from the bottom; the shift-and-or form works for any
   // depth including a single flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= '0;
      end else begin
         stage_q <= (stage_q << 1) | DEPTH'(1);
      end
   end

   assign sync_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rstn_release_sequencer.sv
// ---------------------------------------------------------------------------
// rstn_release_sequencer
//
// Purpose : Drives the active-low RN inputs of the register banks. Reset
//           assertion from the RN pad is asynchronous; deassertion is
//           synchronized to CLK and the NUM_OUT domains are released one by
//           one, in order 0..NUM_OUT-1, STAGE_DELAY cycles apart. A
//           four-phase software request (SW_RST_REQ / SW_RST_ACK) re-runs
//           the sequence from RUN.
//
// Optional build macro:
//   RSTSEQ_STAGED_ASSERT_EN  software reset asserts the domains in reverse
//                            order (NUM_OUT-1 down to 0), one every
//                            STAGE_DELAY cycles, before the hold period.
//                            Without it all domains assert together.
//
// Parameters:
//   NUM_OUT      number of reset domains
//   SYNC_STAGES  deassertion synchronizer depth (>= 2)
//   DELAY_W      width of the stage delay counter
//   STAGE_DELAY  cycles between domain releases, 1 .. 2^DELAY_W-1
//
// Ports:
//   CLK         input  1        rising-edge clock
//   RN          input  1        asynchronous active-low reset
//   SW_RST_REQ  input  1        software reset request (level)
//   SW_RST_ACK  output 1        software reset acknowledge (level)
//   RN_OUT      output NUM_OUT  per-domain active-low resets (registered)
//   DONE        output 1        all domains released (registered)
//   STATE       output 2        current state encoding, for debug
// ---------------------------------------------------------------------------
module rstn_release_sequencer
   import rstseq_pkg::*;
#(
   parameter int NUM_OUT     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DELAY_W     = 8,
   parameter int STAGE_DELAY = 16
) (
   input  logic               CLK,
   input  logic               RN,
   input  logic               SW_RST_REQ,
   output logic               SW_RST_ACK,
   output logic [NUM_OUT-1:0] RN_OUT,
   output logic               DONE,
   output logic [STATE_W-1:0] STATE
);

   localparam int                 STAGE_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [DELAY_W-1:0] LAST_CNT   = DELAY_W'(STAGE_DELAY - 1);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_OUT - 1);

   // Reject parameter sets the counter or the synchronizer cannot honour.
   if (!delayFits(STAGE_DELAY, DELAY_W)) begin : gBadDelay
      $error("rstn_release_sequencer: STAGE_DELAY must be in 1 .. 2^DELAY_W-1");
   end
   if (SYNC_STAGES < 2) begin : gBadSync
      $error("rstn_release_sequencer: SYNC_STAGES must be at least 2");
   end

   rstseq_state_e      state_q;
   logic [DELAY_W-1:0] cnt_q;
   logic [STAGE_W-1:0] stageIdx_q;
   logic [NUM_OUT-1:0] rnOut_q;
   logic               done_q;
   logic               ack_q;
   logic               swSeq_q;
   logic               reqPrev_q;
   logic               syncDone;
   logic               reqRise;

   // The state register's move out of SYNC acts as the last synchronizer
   // flop, so the chain carries SYNC_STAGES-1 flops and RELEASE is entered
   // on rising edge SYNC_STAGES after RN deasserts. Domain i therefore
   // rises on edge SYNC_STAGES + (i+1)*STAGE_DELAY.
   rstn_sync_chain #(
      .DEPTH (SYNC_STAGES - 1)
   ) uSyncChain (
      .clk_i  (CLK),
      .rst_ni (RN),
      .sync_o (syncDone)
   );

   // A request is a sampled 0 -> 1 transition; reqPrev_q is sampled in
   // every state so a level held from before RUN never looks like an edge.
   assign reqRise = SW_RST_REQ & ~reqPrev_q;

   // Sequencer: synchronize, release domains in order, then watch for
   // software requests. Every output is a flop here so nothing on RN_OUT
   // has a combinational path from an input. The ACK clear sits ahead of
   // the case statement so that the set on a software DONE edge wins.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q    <= SYNC;
         cnt_q      <= '0;
         stageIdx_q <= '0;
         rnOut_q    <= '0;
         done_q     <= 1'b0;
         ack_q      <= 1'b0;
         swSeq_q    <= 1'b0;
         reqPrev_q  <= 1'b0;
      end else begin
         reqPrev_q <= SW_RST_REQ;
         if (!SW_RST_REQ) begin
            ack_q <= 1'b0;
         end

         case (state_q)
            SYNC: begin
               if (syncDone) begin
                  state_q    <= RELEASE;
                  cnt_q      <= '0;
                  stageIdx_q <= '0;
               end
            end

            RELEASE: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q               <= '0;
                  rnOut_q[stageIdx_q] <= 1'b1;
                  if (stageIdx_q == LAST_STAGE) begin
                     state_q    <= RUN;
                     done_q     <= 1'b1;
                     stageIdx_q <= '0;
                     swSeq_q    <= 1'b0;
                     if (swSeq_q) begin
                        ack_q <= 1'b1;
                     end
                  end else begin
                     stageIdx_q <= stageIdx_q + STAGE_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + DELAY_W'(1);
               end
            end

            RUN: begin
               if (reqRise && !ack_q) begin
                  state_q <= SW_HOLD;
                  done_q  <= 1'b0;
                  cnt_q   <= '0;
`ifdef RSTSEQ_STAGED_ASSERT_EN
                  rnOut_q[NUM_OUT-1] <= 1'b0;
                  stageIdx_q         <= LAST_STAGE;
`else
                  rnOut_q            <= '0;
                  stageIdx_q         <= '0;
`endif
               end
            end

            SW_HOLD: begin
               // stageIdx_q counts domains still to be asserted; at zero
               // every domain is down and this is the plain hold period.
               if (cnt_q == LAST_CNT) begin
                  cnt_q <= '0;
                  if (stageIdx_q == '0) begin
                     state_q <= RELEASE;
                     swSeq_q <= 1'b1;
                  end else begin
                     rnOut_q[stageIdx_q - STAGE_W'(1)] <= 1'b0;
                     stageIdx_q                        <= stageIdx_q - STAGE_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + DELAY_W'(1);
               end
            end

            default: begin
               state_q <= SYNC;
            end
         endcase
      end
   end

   assign RN_OUT     = rnOut_q;
   assign DONE       = done_q;
   assign SW_RST_ACK = ack_q;
   assign STATE      = state_q;

endmodule
